// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared FSM state type and sizing constants for serial_adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module  : full_adder
// Brief   : One-bit full-adder cell shared by every serial add step.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial adder, LSB first, one bit per clock; WIDTH+2 cycle issue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_s;
    logic               w_cout;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                        Sum     <= '0;
                        Cout    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    // Sum fills from the MSB end so bit order is intact after WIDTH steps.
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    Sum     <= {w_s, Sum[WIDTH-1:1]};
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= DONE;
                        Cout    <= w_cout;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Directed-vector and sequence bench for serial_adder (WIDTH=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int c_w = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [c_w-1:0] A = '0;
    logic [c_w-1:0] B = '0;
    logic           Cin = 1'b0;
    logic [c_w-1:0] Sum;
    logic           Cout;
    logic           busy;
    logic           done;

    int n_vec  = 0;
    int n_fail = 0;

    serial_adder #(.WIDTH(c_w)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One full operation from the IDLE state, checking result and busy/done timing.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        bit ok;
        @(negedge clk);
        A = a; B = b; Cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = ~a; B = 8'($urandom); Cin = ~c;
        ok = busy && !done;
        for (int k = 1; k <= c_w; k++) begin
            @(posedge clk); #1;
            ok = ok && busy && (done == (k == c_w));
            A = 8'($urandom); B = 8'($urandom);
            if (k == c_w) begin
                check({tag, " sum"}, 32'(Sum), 32'(exp_sum));
                check({tag, " cout"}, 32'(Cout), 32'(exp_cout));
            end
        end
        @(posedge clk); #1;
        ok = ok && !busy && !done;
        check({tag, " timing"}, 32'(ok), 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        logic [8:0] r;
        logic [7:0] ra, rb;
        logic       rc;
        logic [7:0] oa[40];
        logic [7:0] ob[40];
        logic       oc[40];
        int         n_done;
        bit         seq_ok;

        vecs[0] = '{8'h35, 8'h0C, 1'b0, 8'h41, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        #23;
        check("reset sum", 32'(Sum), 32'd0);
        check("reset cout", 32'(Cout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

        // Result must hold through idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("idle hold sum", 32'(Sum), 32'h46);
        check("idle hold busy", 32'(busy), 32'd0);

        // start held high with operands changing every cycle.
        for (int e = 0; e < 40; e++) begin
            oa[e] = 8'(e * 37 + 5);
            ob[e] = 8'(e * 91 + 3);
            oc[e] = e[0];
        end
        n_done = 0;
        seq_ok = 1'b1;
        for (int e = 0; e < 32; e++) begin
            @(negedge clk);
            start = 1'b1; A = oa[e]; B = ob[e]; Cin = oc[e];
            @(posedge clk); #1;
            seq_ok = seq_ok && (done == ((e % 10) == 8));
            if (done) begin
                n_done++;
                r = {1'b0, oa[e-8]} + {1'b0, ob[e-8]} + {8'd0, oc[e-8]};
                check($sformatf("b2b sum e%0d", e), 32'(Sum), 32'(r[7:0]));
                check($sformatf("b2b cout e%0d", e), 32'(Cout), 32'(r[8]));
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b done timing", 32'(seq_ok), 32'd1);
        check("b2b done count", 32'(n_done), 32'd3);
        repeat (12) @(posedge clk);

        // Reset on the 4th RUN edge aborts the operation.
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort sum", 32'(Sum), 32'd0);
        check("abort cout", 32'(Cout), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        seq_ok = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            seq_ok = seq_ok && !done && !busy;
        end
        check("abort no done", 32'(seq_ok), 32'd1);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after abort");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            r  = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_op(ra, rb, rc, r[7:0], r[8], $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  augend; sampled on the edge that accepts start.
REQ-006 Port: B  input  WIDTH  addend; sampled on the edge that accepts start.
REQ-007 Port: Cin  input  1  carry-in; sampled on the edge that accepts start.
REQ-008 Port: Sum  output  WIDTH  result, registered; valid from the done cycle until the next accepted start.
REQ-009 Port: Cout  output  1  carry-out, registered; valid with Sum.
REQ-010 Port: busy  output  1  high in RUN and DONE; low in IDLE.
REQ-011 Port: done  output  1  single-cycle completion pulse.

Function
REQ-012 The block SHALL be an FSM with states IDLE, RUN and DONE.
- IDLE->RUN: on an edge with start=1.
- RUN->DONE: after WIDTH RUN edges.
- DONE->IDLE: unconditionally on the next edge.
REQ-013 The accepting edge E0 SHALL load the A and B shift registers, load the carry flop with Cin, clear the bit counter and clear Sum.
REQ-014 Edges E1..EWIDTH in RUN SHALL each add one bit, LSB first, in the full-adder cell:
- sum bit = a0 ^ b0 ^ c; carry = majority(a0, b0, c).
- The sum bit SHALL be shifted into Sum from the MSB end, so after EWIDTH Sum holds A+B+Cin mod 2^WIDTH with bit order preserved.
- A and B registers SHALL shift right one bit per edge.
REQ-015 Cout SHALL equal the carry flop after EWIDTH, i.e. bit WIDTH of A+B+Cin.
REQ-016 done SHALL be high only during the cycle between EWIDTH and EWIDTH+1 (state DONE); latency from the start edge to done high is WIDTH edges.
REQ-017 busy SHALL be high from E0 through EWIDTH+1, i.e. WIDTH+1 cycles.
REQ-018 start SHALL be ignored in RUN and DONE; A, B and Cin changes while busy SHALL NOT affect the result.
REQ-019 A new start is accepted no earlier than the first edge in IDLE after DONE; this gives a back-to-back issue rate of one operation per WIDTH+2 cycles.
REQ-020 Sum and Cout SHALL hold their values in IDLE until the next accepted start.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-022 rst_n=0 SHALL immediately force: state=IDLE, Sum=0, Cout=0, busy=0, done=0, carry=0, counter=0, shift registers=0.
REQ-023 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first rising edge.

Structure
REQ-024 A shared package SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-025 The one-bit add SHALL be a sub-module full_adder (inputs a, b, cin; outputs s, cout), instantiated once and reused every RUN cycle.

Verification
REQ-026 WIDTH=8, A=0x35, B=0x0C, Cin=0, start for 1 cycle -> done on the 8th edge after the start edge; Sum=0x41, Cout=0.
REQ-027 A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
REQ-028 start held high continuously, A/B changed every cycle while busy -> one done per 10 cycles; each result matches the operands sampled at its accepting edge.
REQ-029 rst_n pulsed low on the 4th RUN edge of A=0x12, B=0x34 -> outputs 0 immediately, no done; a following start with A=0x12, B=0x34 -> Sum=0x46, Cout=0.
REQ-030 Random sweep of 1000 (A, B, Cin) triples, checked against a reference model -> all Sum/Cout match; busy and done timing per REQ-016/REQ-017 on every operation.
